// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark word packer.
// Provides pixel/address widths, the default frame size, the FIFO word type
// {waddr, be, data}, the pixel assembly register type and a lane-mask helper.
package wm_pkg;

  localparam int unsigned PIX_W                = 8;
  localparam int unsigned ADDR_W               = 19;
  localparam int unsigned WADDR_W              = 17;
  localparam int unsigned LANES                = 4;
  localparam int unsigned WORD_W               = PIX_W * LANES;
  localparam int unsigned FRAME_PIXELS_DEFAULT = 307200;

  // One FIFO entry as presented on the write port.
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [LANES-1:0]   be;
    logic [WORD_W-1:0]  data;
  } wm_word_t;

  // Word under assembly. done marks it ready to be pushed on the next cycle.
  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic [LANES-1:0]   be;
    logic [WADDR_W-1:0] waddr;
    logic               valid;
    logic               done;
  } wm_asm_t;

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
    lane_mask       = '0;
    lane_mask[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/wm_word_fifo.sv
// Synchronous word FIFO for the packer, first word shown from registers.
// Ports:
//   pclk_i, reset_i   clock and asynchronous active-high reset
//   push_i, wdata_i   write request; accepted when not full or popped this cycle
//   pop_i             read request; ignored when empty
//   rdata_o           head entry (all zero after reset)
//   full_o, empty_o   occupancy flags
//   level_o           registered entry count
// Depth must be a power of two so the pointers wrap naturally.
module wm_word_fifo
  import wm_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   pclk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  wm_word_t               wdata_i,
  input  logic                   pop_i,
  output wm_word_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LvlW = $clog2(Depth) + 1;
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

  wm_word_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DepthLvl);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push != do_pop) begin
        level_q <= do_push ? level_q + LvlW'(1) : level_q - LvlW'(1);
      end
    end
  end

endmodule

// File: rtl/wm_word_packer.sv
// Packs the watermarked pixel stream into 32-bit words with byte enables.
// Ports:
//   pclk, reset               pixel clock, asynchronous active-high reset
//   wked_pixel(_ready/_adrr)  incoming pixel, one-cycle strobe, 19-bit address
//   wr_data/wr_be/wr_addr     packed word, byte enables, word address (adrr >> 2)
//   wr_valid, wr_ready        write-port handshake to the frame-store writer
//   fifo_level                words currently buffered
//   overflow, drop_count      sticky drop flag and saturating dropped-word count
// A word is closed by lane 3, the last pixel of the frame, or FLUSH_TIMEOUT idle
// cycles; an address jump pushes the partial word early.
module wm_word_packer
  import wm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FRAME_PIXELS  = FRAME_PIXELS_DEFAULT,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                        pclk,
  input  logic                        reset,
  input  logic [PIX_W-1:0]            wked_pixel,
  input  logic                        wked_pixel_ready,
  input  logic [ADDR_W-1:0]           wked_pixel_adrr,
  output logic [WORD_W-1:0]           wr_data,
  output logic [LANES-1:0]            wr_be,
  output logic [WADDR_W-1:0]          wr_addr,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  localparam int unsigned ToW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [ToW-1:0]    TimeoutLast = ToW'(FLUSH_TIMEOUT);
  localparam logic [ADDR_W-1:0] FrameLast   = ADDR_W'(FRAME_PIXELS - 1);

  wm_asm_t          asm_q, asm_d;
  logic [ToW-1:0]   idle_cnt_q, idle_cnt_d;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;
  logic             push, pop, drop;
  logic             fifo_full, fifo_empty;
  wm_word_t         push_word, head_word;

  logic [1:0]         p_lane;
  logic [WADDR_W-1:0] p_waddr;
  logic               p_done;

  assign p_lane  = wked_pixel_adrr[1:0];
  assign p_waddr = wked_pixel_adrr[ADDR_W-1:2];
  assign p_done  = (p_lane == 2'd3) || (wked_pixel_adrr == FrameLast);

  always_comb begin
    asm_d      = asm_q;
    idle_cnt_d = idle_cnt_q;
    push       = 1'b0;
    if (wked_pixel_ready) begin
      idle_cnt_d = '0;
      // Finished word, or a partial word at a different address: push it and
      // start over with this pixel alone.
      if (asm_q.done || (asm_q.valid && (p_waddr != asm_q.waddr))) begin
        push       = 1'b1;
        asm_d.data = '0;
        asm_d.be   = '0;
      end
      asm_d.data[PIX_W*int'(p_lane) +: PIX_W] = wked_pixel;
      asm_d.be    = asm_d.be | lane_mask(p_lane);
      asm_d.valid = 1'b1;
      asm_d.waddr = p_waddr;
      asm_d.done  = p_done;
    end else if (asm_q.done) begin
      push       = 1'b1;
      asm_d      = '0;
      idle_cnt_d = '0;
    end else if (asm_q.valid) begin
      idle_cnt_d = idle_cnt_q + ToW'(1);
      if (idle_cnt_d == TimeoutLast) begin
        asm_d.done = 1'b1;
      end
    end
  end

  assign push_word = '{waddr: asm_q.waddr, be: asm_q.be, data: asm_q.data};
  assign wr_valid  = !fifo_empty;
  assign pop       = wr_valid && wr_ready;
  assign drop      = push && fifo_full && !pop;

  wm_word_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .pclk_i  (pclk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      asm_q      <= '0;
      idle_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      asm_q      <= asm_d;
      idle_cnt_q <= idle_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

  assign wr_data    = head_word.data;
  assign wr_be      = head_word.be;
  assign wr_addr    = head_word.waddr;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_wm_word_packer.sv
// Scoreboard bench for wm_word_packer: directed pixel streams push expected
// words into a queue; a negedge monitor pops and compares every accepted word.
module tb_wm_word_packer;

  logic        pclk;
  logic        reset;
  logic [7:0]  wked_pixel;
  logic        wked_pixel_ready;
  logic [18:0] wked_pixel_adrr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [16:0] wr_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [52:0] sb[$];
  int          rise_cyc = -1;
  logic        prev_valid = 1'b0;
  logic        saw_valid = 1'b0;
  int          last_pix_cyc = 0;
  logic        have_snap;
  logic        stable_ok;
  logic [52:0] snap;

  wm_word_packer #(
    .FIFO_DEPTH    (8),
    .FRAME_PIXELS  (307200),
    .FLUSH_TIMEOUT (64)
  ) dut (
    .pclk             (pclk),
    .reset            (reset),
    .wked_pixel       (wked_pixel),
    .wked_pixel_ready (wked_pixel_ready),
    .wked_pixel_adrr  (wked_pixel_adrr),
    .wr_data          (wr_data),
    .wr_be            (wr_be),
    .wr_addr          (wr_addr),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    for (int k = 0; k < 4; k++) be_mask[8*k +: 8] = {8{be[k]}};
  endfunction

  function automatic logic [52:0] mk_word(input int a, input logic [3:0] be,
                                          input logic [31:0] d);
    return {a[16:0], be, d};
  endfunction

  // Monitor: each word accepted by the consumer is checked against the queue head.
  always @(negedge pclk) begin : monitor
    logic [52:0] e;
    logic [31:0] m;
    if (!reset) begin
      if (wr_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
      if (wr_valid) saw_valid = 1'b1;
      if (wr_valid && wr_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got addr=0x%0h be=0x%0h data=0x%0h expected none",
                   wr_addr, wr_be, wr_data);
        end else begin
          e = sb.pop_front();
          m = be_mask(e[35:32]);
          check("word_addr", 64'(wr_addr), 64'(e[52:36]));
          check("word_be", 64'(wr_be), 64'(e[35:32]));
          check("word_data", 64'(wr_data & m), 64'(e[31:0] & m));
        end
      end
    end
    prev_valid = wr_valid;
  end

  task automatic drive_pix(input int addr, input logic [7:0] d);
    wked_pixel_ready = 1'b1;
    wked_pixel_adrr  = addr[18:0];
    wked_pixel       = d;
    last_pix_cyc     = cyc;
    @(posedge pclk);
    #1;
    wked_pixel_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic stab_sample();
    if (wr_valid) begin
      if (!have_snap) begin
        snap      = {wr_addr, wr_be, wr_data};
        have_snap = 1'b1;
      end else if ({wr_addr, wr_be, wr_data} !== snap) begin
        stable_ok = 1'b0;
      end
    end
  endtask

  initial begin
    int c3;
    int c9;
    logic [31:0] d;
    reset            = 1'b1;
    wked_pixel       = '0;
    wked_pixel_ready = 1'b0;
    wked_pixel_adrr  = '0;
    wr_ready         = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_wr_valid", 64'(wr_valid), 0);
    check("rst_wr_data", 64'(wr_data), 0);
    check("rst_wr_be", 64'(wr_be), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_fifo_level", 64'(fifo_level), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_drop_count", 64'(drop_count), 0);
    reset    = 1'b0;
    wr_ready = 1'b1;
    idle(2);

    // Sequential addresses 0..7: two full words, first visible 2 cycles after lane 3.
    sb.push_back(mk_word(0, 4'hF, 32'h13121110));
    sb.push_back(mk_word(1, 4'hF, 32'h17161514));
    rise_cyc = -1;
    c3 = 0;
    for (int i = 0; i < 8; i++) begin
      drive_pix(i, 8'h10 + 8'(i));
      if (i == 3) c3 = last_pix_cyc;
    end
    idle(6);
    check("t1_latency", 64'(rise_cyc - c3), 2);

    // Discontinuity: addrs 4,5 then 100.
    sb.push_back(mk_word(1, 4'b0011, 32'h0000A1A0));
    drive_pix(4, 8'hA0);
    drive_pix(5, 8'hA1);
    drive_pix(100, 8'hB0);

    // Frame end closes the word at once; addr 0 then starts a fresh word.
    sb.push_back(mk_word(25, 4'b0001, 32'h000000B0));
    sb.push_back(mk_word(76799, 4'b1100, 32'h66550000));
    sb.push_back(mk_word(0, 4'hF, 32'h7A797877));
    drive_pix(307198, 8'h55);
    drive_pix(307199, 8'h66);
    drive_pix(0, 8'h77);
    drive_pix(1, 8'h78);
    drive_pix(2, 8'h79);
    drive_pix(3, 8'h7A);
    idle(4);
    check("t3_no_timeout_wait", 64'(sb.size()), 0);

    // Idle flush of a single pixel.
    sb.push_back(mk_word(2, 4'b0010, 32'h00003C00));
    rise_cyc = -1;
    drive_pix(9, 8'h3C);
    c9 = last_pix_cyc;
    idle(70);
    check("t4_timeout_latency", 64'(rise_cyc - c9), 66);

    // Overflow: 40 full words into a stalled port.
    wr_ready  = 1'b0;
    have_snap = 1'b0;
    stable_ok = 1'b1;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*w + k) ^ 8'h5A;
      sb.push_back(mk_word(250 + w, 4'hF, d));
    end
    for (int i = 0; i < 160; i++) begin
      drive_pix(1000 + i, 8'(i) ^ 8'h5A);
      stab_sample();
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      stab_sample();
    end
    check("t5_fifo_level", 64'(fifo_level), 8);
    check("t5_overflow", 64'(overflow), 1);
    check("t5_drop_count", 64'(drop_count), 32);
    check("t5_stable", 64'({have_snap, stable_ok}), 3);
    wr_ready = 1'b1;
    idle(12);
    check("t5_drained", 64'(sb.size()), 0);
    check("t5_level_empty", 64'(fifo_level), 0);

    // Reset in the middle of a word discards it.
    drive_pix(20, 8'h11);
    drive_pix(21, 8'h22);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("t6_wr_valid", 64'(wr_valid), 0);
    check("t6_fifo_level", 64'(fifo_level), 0);
    check("t6_overflow", 64'(overflow), 0);
    check("t6_drop_count", 64'(drop_count), 0);
    saw_valid = 1'b0;
    idle(80);
    check("t6_no_emit", 64'(saw_valid), 0);
    sb.push_back(mk_word(5, 4'hF, 32'h44332211));
    drive_pix(20, 8'h11);
    drive_pix(21, 8'h22);
    drive_pix(22, 8'h33);
    drive_pix(23, 8'h44);
    idle(6);

    for (int k = 0; k < 200 && sb.size() != 0; k++) idle(1);
    check("sb_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
